logic_unit_pipe: RTL and testbench



---
 rtl/logic_unit_pipe_pkg.sv | 34 +++
 rtl/logic_unit_pipe_if.sv | 30 +++
 rtl/logic_unit_pipe_stage.sv | 46 ++++
 rtl/logic_unit_pipe.sv | 96 +++++++++
 tb/tb_logic_unit_pipe.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/logic_unit_pipe_pkg.sv
// Opcode encoding and per-bit logic function shared by the pipeline and its users.
// apply_op works on one bit; callers apply it across their own operand width.
package logic_unit_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_BUF  = 3'd0,
      OP_NOT  = 3'd1,
      OP_AND  = 3'd2,
      OP_NAND = 3'd3,
      OP_OR   = 3'd4,
      OP_NOR  = 3'd5,
      OP_XOR  = 3'd6,
      OP_XNOR = 3'd7
   } op_e;

   function automatic logic apply_op(input op_e op, input logic a, input logic b);
      logic r;
      case (op)
         OP_BUF:  r = a;
         OP_NOT:  r = ~a;
         OP_AND:  r = a & b;
         OP_NAND: r = ~(a & b);
         OP_OR:   r = a | b;
         OP_NOR:  r = ~(a | b);
         OP_XOR:  r = a ^ b;
         OP_XNOR: r = ~(a ^ b);
         default: r = a;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle; master is the source+consumer side, slave is the pipeline.
interface logic_unit_pipe_if
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 8
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   op_e              in_op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_y;
   op_e              out_op;
   logic             out_zero;
   logic             out_parity;

   modport master (
      output in_valid, in_a, in_b, in_op, out_ready,
      input  in_ready, out_valid, out_y, out_op, out_zero, out_parity
   );

   modport slave (
      input  in_valid, in_a, in_b, in_op, out_ready,
      output in_ready, out_valid, out_y, out_op, out_zero, out_parity
   );

endinterface

// File: rtl/logic_unit_pipe_stage.sv
// Single valid/ready register slice; ready_o is combinational from ready_i (no skid).
// Data holds its last value while empty; reset loads RST_VAL.
module logic_stage #(
   parameter int           W       = 8,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         valid_i,
   input  logic [W-1:0] data_i,
   output logic         ready_o,
   input  logic         ready_i,
   output logic         valid_o,
   output logic [W-1:0] data_o
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;

   assign ready_o = !valid_q || ready_i;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (ready_o) begin
         valid_d = valid_i;
      end
      if (valid_i && ready_o) begin
         data_d = data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= RST_VAL;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with result flags and a completed-transfer counter.
// Operands are registered, the function is computed between the slices, result and flags registered.
module logic_unit_pipe
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   logic_unit_pipe_if.slave  bus,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  done_cnt
);

   typedef struct packed {
      op_e              op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } s1_t;

   typedef struct packed {
      op_e              op;
      logic             zero;
      logic             parity;
      logic [WIDTH-1:0] y;
   } s2_t;

   localparam int  S1_W   = $bits(s1_t);
   localparam int  S2_W   = $bits(s2_t);
   // Empty result after reset reads as zero, so the zero flag starts set.
   localparam s2_t S2_RST = '{op: OP_BUF, zero: 1'b1, parity: 1'b0, y: '0};

   s1_t              s1_in, s1_out;
   s2_t              s2_in, s2_out;
   logic             s1_vld, s2_vld, s2_rdy;
   logic [WIDTH-1:0] y_c;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign s1_in = '{op: bus.in_op, a: bus.in_a, b: bus.in_b};

   logic_stage #(.W(S1_W)) u_s1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (bus.in_valid),
      .data_i  (s1_in),
      .ready_o (bus.in_ready),
      .ready_i (s2_rdy),
      .valid_o (s1_vld),
      .data_o  (s1_out)
   );

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign y_c[i] = apply_op(s1_out.op, s1_out.a[i], s1_out.b[i]);
   end

   assign s2_in = '{op: s1_out.op, zero: ~|y_c, parity: ^y_c, y: y_c};

   logic_stage #(.W(S2_W), .RST_VAL(S2_RST)) u_s2 (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (s1_vld),
      .data_i  (s2_in),
      .ready_o (s2_rdy),
      .ready_i (bus.out_ready),
      .valid_o (s2_vld),
      .data_o  (s2_out)
   );

   assign bus.out_valid  = s2_vld;
   assign bus.out_y      = s2_out.y;
   assign bus.out_op     = s2_out.op;
   assign bus.out_zero   = s2_out.zero;
   assign bus.out_parity = s2_out.parity;

   // Clear wins over a same-cycle transfer.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (s2_vld && bus.out_ready) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_cnt = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Randomized self-checking bench for logic_unit_pipe against a transaction-level reference queue.
module tb_logic_unit_pipe;
   import logic_unit_pkg::*;

   typedef struct packed {
      op_e        op;
      logic [7:0] y;
      logic       zero;
      logic       parity;
   } res_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cnt_clr = 1'b0;
   logic        cnt_clr4 = 1'b0;
   logic [15:0] done_cnt;
   logic [3:0]  done_cnt4;

   int errors = 0;
   int checks = 0;
   int cyc_n  = 0;
   res_t exp_q[$];
   res_t got_q[$];
   int   got_cyc[$];

   logic_unit_pipe_if #(.WIDTH(8)) bus ();
   logic_unit_pipe_if #(.WIDTH(8)) bus4 ();

   logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .cnt_clr(cnt_clr), .done_cnt(done_cnt)
   );

   logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .bus(bus4), .cnt_clr(cnt_clr4), .done_cnt(done_cnt4)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, summary errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   function automatic res_t ref_model(input op_e op, input logic [7:0] a, input logic [7:0] b);
      res_t r;
      logic [7:0] y;
      case (op)
         OP_BUF:  y = a;
         OP_NOT:  y = 8'hFF - a;
         OP_AND:  y = a & b;
         OP_NAND: y = 8'hFF - (a & b);
         OP_OR:   y = a | b;
         OP_NOR:  y = 8'hFF - (a | b);
         OP_XOR:  y = (a | b) - (a & b);
         default: y = 8'hFF - ((a | b) - (a & b));
      endcase
      r.op = op;
      r.y = y;
      r.zero = (y == 8'd0);
      r.parity = ($countones(y) % 2) == 1;
      return r;
   endfunction

   // Observes handshakes just before the edge, then returns 1 time unit after it.
   task automatic cycle(output bit acc, output bit xfer);
      @(negedge clk);
      acc  = bus.in_valid && bus.in_ready;
      xfer = bus.out_valid && bus.out_ready;
      if (acc) exp_q.push_back(ref_model(bus.in_op, bus.in_a, bus.in_b));
      if (xfer) begin
         got_q.push_back('{op: bus.out_op, y: bus.out_y, zero: bus.out_zero, parity: bus.out_parity});
         got_cyc.push_back(cyc_n);
      end
      @(posedge clk);
      #1;
      cyc_n++;
   endtask

   task automatic tick();
      bit a, x;
      cycle(a, x);
   endtask

   task automatic clear_model();
      exp_q.delete();
      got_q.delete();
      got_cyc.delete();
   endtask

   task automatic drive_rand(input op_e op);
      bus.in_a  = 8'($urandom);
      bus.in_b  = 8'($urandom);
      bus.in_op = op;
   endtask

   task automatic run_one(input op_e op, input logic [7:0] a, input logic [7:0] b, output bit early);
      bit ac, xf;
      bus.in_valid = 1'b1;
      bus.in_a = a;
      bus.in_b = b;
      bus.in_op = op;
      cycle(ac, xf);
      bus.in_valid = 1'b0;
      early = !ac || (bus.out_valid !== 1'b0);
      cycle(ac, xf);
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = OP_BUF; bus.out_ready = 1'b0;
      bus4.in_valid = 1'b0; bus4.in_a = '0; bus4.in_b = '0; bus4.in_op = OP_BUF; bus4.out_ready = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      checks++; if (bus.out_y !== 8'h00) begin errors++; $display("FAIL reset_out_y: got %h want 00", bus.out_y); end
      checks++; if (bus.out_op !== OP_BUF) begin errors++; $display("FAIL reset_out_op: got %0d want 0", bus.out_op); end
      checks++; if (bus.out_zero !== 1'b1) begin errors++; $display("FAIL reset_out_zero: got %b want 1", bus.out_zero); end
      checks++; if (bus.out_parity !== 1'b0) begin errors++; $display("FAIL reset_out_parity: got %b want 0", bus.out_parity); end
      checks++; if (done_cnt !== 16'd0) begin errors++; $display("FAIL reset_done_cnt: got %0d want 0", done_cnt); end
      checks++; if (done_cnt4 !== 4'd0) begin errors++; $display("FAIL reset_done_cnt4: got %0d want 0", done_cnt4); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
      clear_model();
   endtask

   task automatic test_all_ops();
      logic [7:0] tbl [8];
      bit early;
      tbl = '{8'hA5, 8'h5A, 8'h05, 8'hFA, 8'hAF, 8'h50, 8'hAA, 8'h55};
      bus.out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         run_one(op_e'(3'(k)), 8'hA5, 8'h0F, early);
         checks++; if (early) begin errors++; $display("FAIL ops_latency op%0d: early/unaccepted result", k); end
         checks++; if (bus.out_valid !== 1'b1 || bus.out_y !== tbl[k]) begin
            errors++; $display("FAIL ops_result op%0d: got vld=%b y=%h want vld=1 y=%h", k, bus.out_valid, bus.out_y, tbl[k]);
         end
         checks++; if (bus.out_parity !== 1'b0 || bus.out_op !== op_e'(3'(k))) begin
            errors++; $display("FAIL ops_flags op%0d: got par=%b op=%0d want par=0 op=%0d", k, bus.out_parity, bus.out_op, k);
         end
         tick();
      end
      clear_model();
   endtask

   task automatic test_zero_flag();
      bit early;
      bus.out_ready = 1'b1;
      run_one(OP_AND, 8'hF0, 8'h0F, early);
      checks++; if (early || bus.out_y !== 8'h00 || bus.out_zero !== 1'b1 || bus.out_parity !== 1'b0) begin
         errors++; $display("FAIL zero_and: got y=%h z=%b p=%b want y=00 z=1 p=0", bus.out_y, bus.out_zero, bus.out_parity);
      end
      tick();
      run_one(OP_XNOR, 8'h00, 8'h00, early);
      checks++; if (early || bus.out_y !== 8'hFF || bus.out_zero !== 1'b0 || bus.out_parity !== 1'b0) begin
         errors++; $display("FAIL zero_xnor: got y=%h z=%b p=%b want y=FF z=0 p=0", bus.out_y, bus.out_zero, bus.out_parity);
      end
      tick();
      clear_model();
   endtask

   task automatic test_backpressure();
      bit ac, xf;
      int idx = 0;
      int budget;
      cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
      clear_model();
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      drive_rand(OP_XOR);
      budget = 0;
      while (idx < 2 && budget < 10) begin
         cycle(ac, xf); budget++;
         if (ac) begin idx++; drive_rand(OP_XOR); end
      end
      checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
         errors++; $display("FAIL bp_full: got in_ready=%b out_valid=%b want 0/1", bus.in_ready, bus.out_valid);
      end
      for (int h = 0; h < 3; h++) begin
         cycle(ac, xf);
         checks++; if (ac || exp_q.size() == 0 || bus.out_y !== exp_q[0].y || bus.out_op !== OP_XOR) begin
            errors++; $display("FAIL bp_hold%0d: got y=%h acc=%b want held first result", h, bus.out_y, ac);
         end
      end
      bus.out_ready = 1'b1;
      budget = 0;
      while (got_q.size() < 4 && budget < 20) begin
         cycle(ac, xf); budget++;
         if (ac) begin
            idx++;
            if (idx < 4) drive_rand(OP_XOR); else bus.in_valid = 1'b0;
         end
      end
      bus.in_valid = 1'b0;
      checks++; if (got_q.size() != 4 || exp_q.size() != 4) begin
         errors++; $display("FAIL bp_count: got %0d results for %0d accepts want 4", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL bp_item%0d: got %h want %h", i, got_q[i], exp_q[i]);
         end
      end
      checks++; if (got_q.size() == 4 && got_cyc[3] - got_cyc[0] != 3) begin
         errors++; $display("FAIL bp_drain_rate: got span %0d want 3", got_cyc[3] - got_cyc[0]);
      end
      checks++; if (done_cnt !== 16'd4) begin errors++; $display("FAIL bp_done_cnt: got %0d want 4", done_cnt); end
      clear_model();
   endtask

   task automatic test_back_to_back();
      bit ac, xf;
      int n_acc = 0;
      int budget = 0;
      cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
      clear_model();
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1;
      drive_rand(op_e'(3'($urandom)));
      while (n_acc < 20 && budget < 40) begin
         cycle(ac, xf); budget++;
         if (ac) begin n_acc++; drive_rand(op_e'(3'($urandom))); end
         if (n_acc == 20) bus.in_valid = 1'b0;
      end
      bus.in_valid = 1'b0;
      checks++; if (budget != 20) begin errors++; $display("FAIL b2b_in_rate: got %0d cycles for 20 accepts want 20", budget); end
      budget = 0;
      while (got_q.size() < 20 && budget < 10) begin tick(); budget++; end
      checks++; if (got_q.size() != 20) begin errors++; $display("FAIL b2b_count: got %0d want 20", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL b2b_item%0d: got %h want %h", i, got_q[i], exp_q[i]);
         end
      end
      checks++; if (got_q.size() == 20 && got_cyc[19] - got_cyc[0] != 19) begin
         errors++; $display("FAIL b2b_out_rate: got span %0d want 19", got_cyc[19] - got_cyc[0]);
      end
      checks++; if (done_cnt !== 16'd20) begin errors++; $display("FAIL b2b_done_cnt: got %0d want 20", done_cnt); end
      clear_model();
   endtask

   task automatic test_counter_wrap();
      bus4.out_ready = 1'b1;
      cnt_clr4 = 1'b1; tick(); cnt_clr4 = 1'b0;
      bus4.in_valid = 1'b1;
      for (int i = 0; i < 17; i++) begin
         bus4.in_a = 8'($urandom); bus4.in_b = 8'($urandom); bus4.in_op = op_e'(3'($urandom));
         tick();
      end
      bus4.in_valid = 1'b0;
      tick(); tick(); tick();
      checks++; if (done_cnt4 !== 4'd1) begin errors++; $display("FAIL cnt_wrap: got %0d want 1", done_cnt4); end
      bus4.in_valid = 1'b1;
      tick(); tick();
      bus4.in_valid = 1'b0;
      checks++; if (bus4.out_valid !== 1'b1 || done_cnt4 !== 4'd1) begin
         errors++; $display("FAIL cnt_pre_clr: got vld=%b cnt=%0d want 1/1", bus4.out_valid, done_cnt4);
      end
      cnt_clr4 = 1'b1; tick(); cnt_clr4 = 1'b0;
      checks++; if (done_cnt4 !== 4'd0) begin errors++; $display("FAIL cnt_clr_prio: got %0d want 0", done_cnt4); end
      tick();
      checks++; if (done_cnt4 !== 4'd1) begin errors++; $display("FAIL cnt_after_clr: got %0d want 1", done_cnt4); end
   endtask

   task automatic test_async_reset();
      bit ac, xf;
      int n = 0;
      int budget = 0;
      clear_model();
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      drive_rand(OP_OR);
      while (n < 2 && budget < 10) begin
         cycle(ac, xf); budget++;
         if (ac) begin n++; drive_rand(OP_NAND); end
      end
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || done_cnt !== 16'd20) begin
         errors++; $display("FAIL arst_pre: got vld=%b rdy=%b cnt=%0d want 1/0/20", bus.out_valid, bus.in_ready, done_cnt);
      end
      #3;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.out_valid !== 1'b0 || done_cnt !== 16'd0 || done_cnt4 !== 4'd0) begin
         errors++; $display("FAIL arst_immediate: got vld=%b cnt=%0d cnt4=%0d want 0/0/0", bus.out_valid, done_cnt, done_cnt4);
      end
      checks++; if (bus.out_zero !== 1'b1 || bus.out_y !== 8'h00) begin
         errors++; $display("FAIL arst_outputs: got z=%b y=%h want 1/00", bus.out_zero, bus.out_y);
      end
      clear_model();
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready: got %b want 1", bus.in_ready); end
      for (int i = 0; i < 5; i++) tick();
      checks++; if (got_q.size() != 0) begin errors++; $display("FAIL arst_stale: got %0d results want 0", got_q.size()); end
   endtask

   initial begin
      test_reset();
      test_all_ops();
      test_zero_flag();
      test_backpressure();
      test_back_to_back();
      test_counter_wrap();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
